up_down_counter_param: RTL and testbench

- Parametrised successor to the team's 8-bit up counter.
- Generalised to configurable width, modulus and step size.
- Adds up/down direction, parallel load, synchronous clear, and wrap or saturate mode.
- Reports a terminal-count pulse and a sticky overflow flag, for use as event counters, timers and address generators in datapath blocks.

---
 rtl/up_down_counter_param.sv | 85 ++++++++
 tb/tb_up_down_counter_param.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/up_down_counter_param.sv
// Parametrised up/down counter with step size, parallel load, synchronous clear,
// wrap or saturate at a configurable modulus, terminal-count pulse and sticky overflow.
module up_down_counter_param #(
  parameter int              WIDTH    = 8,
  parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
  parameter int              STEP_W   = 4,
  parameter bit              SATURATE = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_value,
  input  logic              up_down,
  input  logic [STEP_W-1:0] step,
  output logic [WIDTH-1:0]  out,
  output logic              tc,
  output logic              ovf
);

  // One guard bit above the wider of count and step keeps sums and compares exact.
  localparam int EW = ((STEP_W > WIDTH) ? STEP_W : WIDTH) + 1;
  localparam logic [EW-1:0] MAX_E = EW'(MAX_VAL);
  localparam logic [EW-1:0] MOD_E = MAX_E + EW'(1);

  logic [EW-1:0]    cur_e;
  logic [EW-1:0]    step_e;
  logic [EW-1:0]    step_c;
  logic [EW-1:0]    load_e;
  logic [EW-1:0]    sum_e;
  logic [WIDTH-1:0] nxt_out;
  logic             nxt_tc;
  logic             nxt_ovf;

  always_comb begin
    cur_e   = EW'(out);
    step_e  = EW'(step);
    load_e  = EW'(load_value);
    // Clamping the step keeps a wrap from ever crossing the boundary twice.
    step_c  = (step_e > MAX_E) ? MAX_E : step_e;
    sum_e   = cur_e + step_c;
    nxt_out = out;
    nxt_tc  = 1'b0;
    nxt_ovf = ovf;

    if (clear) begin
      nxt_out = '0;
      nxt_ovf = 1'b0;
    end else if (load) begin
      nxt_out = (load_e > MAX_E) ? WIDTH'(MAX_E) : load_value;
    end else if (enable) begin
      if (up_down) begin
        if (sum_e <= MAX_E) begin
          nxt_out = WIDTH'(sum_e);
        end else begin
          nxt_tc  = 1'b1;
          nxt_ovf = 1'b1;
          nxt_out = SATURATE ? WIDTH'(MAX_E) : WIDTH'(sum_e - MOD_E);
        end
      end else begin
        if (cur_e >= step_c) begin
          nxt_out = WIDTH'(cur_e - step_c);
        end else begin
          nxt_tc  = 1'b1;
          nxt_ovf = 1'b1;
          nxt_out = SATURATE ? '0 : WIDTH'(cur_e + MOD_E - step_c);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out <= '0;
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      out <= nxt_out;
      tc  <= nxt_tc;
      ovf <= nxt_ovf;
    end
  end

endmodule

// File: tb/tb_up_down_counter_param.sv
// Scoreboard bench for up_down_counter_param: three configurations (default wrap,
// mod-10 wrap, saturate at 200) driven by directed vectors with hand-computed results.
module tb_up_down_counter_param;

  typedef struct {
    int         d;
    logic [7:0] out;
    logic       tc;
    logic       ovf;
    string      name;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       clear;
  logic       load;
  logic       up_down;
  logic [3:0] step;
  logic [7:0] load_value;
  logic [1:0] sel;

  logic [7:0] a_out;
  logic       a_tc, a_ovf;
  logic [3:0] b_out;
  logic       b_tc, b_ovf;
  logic [7:0] c_out;
  logic       c_tc, c_ovf;

  exp_t sb[$];
  int   total;
  int   passes;

  up_down_counter_param dut_a (
    .clk(clk), .reset(reset),
    .enable(enable & (sel == 2'd0)), .clear(clear & (sel == 2'd0)), .load(load & (sel == 2'd0)),
    .load_value(load_value), .up_down(up_down), .step(step),
    .out(a_out), .tc(a_tc), .ovf(a_ovf)
  );

  up_down_counter_param #(.WIDTH(4), .MAX_VAL(9), .STEP_W(4), .SATURATE(1'b0)) dut_b (
    .clk(clk), .reset(reset),
    .enable(enable & (sel == 2'd1)), .clear(clear & (sel == 2'd1)), .load(load & (sel == 2'd1)),
    .load_value(load_value[3:0]), .up_down(up_down), .step(step),
    .out(b_out), .tc(b_tc), .ovf(b_ovf)
  );

  up_down_counter_param #(.WIDTH(8), .MAX_VAL(200), .STEP_W(4), .SATURATE(1'b1)) dut_c (
    .clk(clk), .reset(reset),
    .enable(enable & (sel == 2'd2)), .clear(clear & (sel == 2'd2)), .load(load & (sel == 2'd2)),
    .load_value(load_value), .up_down(up_down), .step(step),
    .out(c_out), .tc(c_tc), .ovf(c_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic pushExp(input int d, input logic [7:0] eo, input logic et, input logic ev,
                         input string name);
    exp_t e;
    e.d = d; e.out = eo; e.tc = et; e.ovf = ev; e.name = name;
    sb.push_back(e);
  endtask

  // Drive one cycle of stimulus to the selected counter, then queue its expected state.
  task automatic applyStimulus(input int d, input logic clr, input logic ld, input logic en,
                               input logic ud, input logic [3:0] st, input logic [7:0] lv,
                               input logic [7:0] eo, input logic et, input logic ev,
                               input string name);
    @(negedge clk);
    sel = 2'(d); clear = clr; load = ld; enable = en; up_down = ud; step = st; load_value = lv;
    @(posedge clk);
    #1;
    sel = 2'd3; clear = 1'b0; load = 1'b0; enable = 1'b0;
    pushExp(d, eo, et, ev, name);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [7:0] ao;
    logic       at, av;
    case (e.d)
      0:       begin ao = a_out;         at = a_tc; av = a_ovf; end
      1:       begin ao = {4'd0, b_out}; at = b_tc; av = b_ovf; end
      default: begin ao = c_out;         at = c_tc; av = c_ovf; end
    endcase
    total++;
    if (ao === e.out && at === e.tc && av === e.ovf)
      passes++;
    else
      $display("[TB] FAIL %s (dut %0d): got out=%0d tc=%0b ovf=%0b, expected out=%0d tc=%0b ovf=%0b",
               e.name, e.d, ao, at, av, e.out, e.tc, e.ovf);
  endtask

  // Monitor: outputs are registered, so every queued expectation is due at the next falling edge.
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0) checkOutput(sb.pop_front());
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    total = 0; passes = 0;
    sel = 2'd3; enable = 1'b0; clear = 1'b0; load = 1'b0; up_down = 1'b1;
    step = 4'd0; load_value = 8'd0;
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    pushExp(0, 8'd0, 1'b0, 1'b0, "reset A");
    pushExp(1, 8'd0, 1'b0, 1'b0, "reset B");
    pushExp(2, 8'd0, 1'b0, 1'b0, "reset C");
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Default configuration: count, async reset, native wrap, priority, holds.
    for (int i = 1; i <= 5; i++)
      applyStimulus(0, 0, 0, 1, 1, 4'd1, 8'd0, 8'(i), 1'b0, 1'b0, "count up");
    @(posedge clk);
    #2 reset = 1'b1;
    pushExp(0, 8'd0, 1'b0, 1'b0, "async reset mid-cycle");
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(0, 0, 0, 1, 1, 4'd1,  8'd0,   8'd1,   1'b0, 1'b0, "step after reset");
    applyStimulus(0, 0, 1, 0, 1, 4'd0,  8'd254, 8'd254, 1'b0, 1'b0, "load 254");
    applyStimulus(0, 0, 0, 1, 1, 4'd3,  8'd0,   8'd1,   1'b1, 1'b1, "native wrap up");
    applyStimulus(0, 1, 1, 1, 1, 4'd1,  8'h40,  8'd0,   1'b0, 1'b0, "priority clear");
    applyStimulus(0, 0, 1, 1, 1, 4'd1,  8'h40,  8'h40,  1'b0, 1'b0, "priority load");
    applyStimulus(0, 0, 0, 1, 1, 4'd0,  8'd0,   8'h40,  1'b0, 1'b0, "step zero hold");
    applyStimulus(0, 0, 0, 1, 1, 4'd15, 8'd0,   8'h4F,  1'b0, 1'b0, "up step 15");
    applyStimulus(0, 0, 1, 0, 1, 4'd0,  8'd2,   8'd2,   1'b0, 1'b0, "load 2");
    applyStimulus(0, 0, 0, 1, 0, 4'd5,  8'd0,   8'd253, 1'b1, 1'b1, "native wrap down");
    applyStimulus(0, 0, 1, 0, 1, 4'd0,  8'd7,   8'd7,   1'b0, 1'b1, "load keeps ovf");
    for (int i = 0; i < 10; i++)
      applyStimulus(0, 0, 0, 0, 1, 4'd3, 8'd0, 8'd7, 1'b0, 1'b1, "idle hold");

    // Mod-10 wrap configuration.
    applyStimulus(1, 0, 1, 0, 1, 4'd0,  8'd8, 8'd8, 1'b0, 1'b0, "B load 8");
    applyStimulus(1, 0, 0, 1, 1, 4'd3,  8'd0, 8'd1, 1'b1, 1'b1, "B wrap up");
    applyStimulus(1, 0, 0, 1, 1, 4'd3,  8'd0, 8'd4, 1'b0, 1'b1, "B step after wrap");
    applyStimulus(1, 0, 0, 1, 1, 4'd15, 8'd0, 8'd3, 1'b1, 1'b1, "B step clamp");
    applyStimulus(1, 0, 0, 1, 0, 4'd2,  8'd0, 8'd1, 1'b0, 1'b1, "B down");
    applyStimulus(1, 0, 0, 1, 0, 4'd2,  8'd0, 8'd9, 1'b1, 1'b1, "B wrap down");
    applyStimulus(1, 1, 0, 0, 1, 4'd0,  8'd0, 8'd0, 1'b0, 1'b0, "B clear");

    // Saturating configuration, limit 200.
    applyStimulus(2, 0, 1, 0, 1, 4'd0, 8'd198, 8'd198, 1'b0, 1'b0, "C load 198");
    applyStimulus(2, 0, 0, 1, 1, 4'd5, 8'd0,   8'd200, 1'b1, 1'b1, "C saturate up");
    applyStimulus(2, 0, 0, 1, 1, 4'd5, 8'd0,   8'd200, 1'b1, 1'b1, "C saturate up again");
    applyStimulus(2, 0, 1, 0, 1, 4'd0, 8'd3,   8'd3,   1'b0, 1'b1, "C load 3");
    applyStimulus(2, 0, 0, 1, 0, 4'd5, 8'd0,   8'd0,   1'b1, 1'b1, "C saturate down");
    applyStimulus(2, 0, 0, 1, 0, 4'd5, 8'd0,   8'd0,   1'b1, 1'b1, "C saturate down again");
    applyStimulus(2, 0, 0, 1, 0, 4'd0, 8'd0,   8'd0,   1'b0, 1'b1, "C step zero at limit");
    applyStimulus(2, 0, 1, 0, 1, 4'd0, 8'd250, 8'd200, 1'b0, 1'b1, "C load clamp");
    applyStimulus(2, 0, 0, 0, 1, 4'd5, 8'd0,   8'd200, 1'b0, 1'b1, "C idle");

    repeat (2) @(negedge clk);
    if (sb.size() != 0) begin
      total++;
      $display("[TB] FAIL scoreboard drain: got %0d pending, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
